// File: rtl/ppa_sub_pkg.sv
// ppa_sub_pkg: shared types and elaboration helpers for the pipelined
// parallel-prefix subtractor (ppa_sub_pipe and its prefix-level sub-module).
//
// Contents:
//   pg_t        - one propagate/generate pair at a prefix position
//   levels()    - number of Kogge-Stone levels for an operand width
//   split_level() - last prefix level evaluated before the middle pipeline
//                   register (SPLIT_LEVEL = (LEVELS+1)/2)
package ppa_sub_pkg;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  function automatic int levels(input int width);
    return $clog2(width);
  endfunction

  // The first half of the levels (rounded up) is done ahead of the middle
  // register, the rest together with post-processing ahead of the output.
  function automatic int split_level(input int lv);
    return (lv + 1) / 2;
  endfunction

endpackage

// File: rtl/ppa_sub_prefix_level.sv
// ppa_sub_prefix_level: one combinational Kogge-Stone level.
//
// Every position i >= DIST gets a black cell combining (i) with (i - DIST);
// positions below DIST pass through unchanged.
//
// Ports:
//   pg_i  in   WIDTH x pg_t  group propagate/generate from the previous level
//   pg_o  out  WIDTH x pg_t  group propagate/generate after this level
module ppa_sub_prefix_level
  import ppa_sub_pkg::*;
#(
  parameter int DIST  = 1,
  parameter int WIDTH = 16
) (
  input  pg_t [WIDTH-1:0] pg_i,
  output pg_t [WIDTH-1:0] pg_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_pos
    if (i >= DIST) begin : g_black
      assign pg_o[i].g = pg_i[i].g | (pg_i[i].p & pg_i[i-DIST].g);
      assign pg_o[i].p = pg_i[i].p & pg_i[i-DIST].p;
    end else begin : g_pass
      assign pg_o[i] = pg_i[i];
    end
  end

endmodule

// File: rtl/ppa_sub_pipe.sv
// ppa_sub_pipe: three-stage pipelined Kogge-Stone subtractor with
// valid/ready flow control. Computes diff = a - b - bin (mod 2^WIDTH),
// the unsigned borrow-out and the two's-complement overflow flag.
//
// Subtraction is done as a + ~b + ~bin, so the prefix tree sees the
// complemented subtrahend and an inverted carry-in; borrow-out is the
// inverted carry-out.
//
// Prefix positions: position 0 holds the carry-in pair (p = 0, g = ~bin),
// position i+1 holds bit i. After all levels, the group generate at
// position i is the carry into bit i.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand beat valid
//   in_ready   out  beat accepted this cycle when in_valid is also high
//   a, b       in   WIDTH  minuend / subtrahend
//   bin        in   borrow-in
//   out_valid  out  result beat valid
//   out_ready  in   consumer takes the result this cycle
//   diff       out  WIDTH  (a - b - bin) mod 2^WIDTH
//   bout       out  1 iff a < b + bin (unsigned)
//   ovf        out  signed overflow
module ppa_sub_pipe
  import ppa_sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int LEVELS      = levels(WIDTH);
  localparam int SPLIT_LEVEL = split_level(LEVELS);

  // Handshake
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic en1, en2, en3;
  logic ld1, ld2, ld3;

  // Stage 1 (pre-processed operands)
  logic [WIDTH-1:0] s1_p_q, s1_p_d, s1_g_q, s1_g_d;
  pg_t              s1_cin_q, s1_cin_d;
  logic             s1_a_msb_q, s1_a_msb_d, s1_b_msb_q, s1_b_msb_d;

  // Stage 2 (group p/g after SPLIT_LEVEL levels)
  pg_t  [WIDTH-1:0] s2_pg_q, s2_pg_d;
  logic [WIDTH-1:0] s2_p_q, s2_p_d;
  logic             s2_g_msb_q, s2_g_msb_d;
  logic             s2_a_msb_q, s2_a_msb_d, s2_b_msb_q, s2_b_msb_d;

  // Stage 3 (outputs)
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d, ovf_q, ovf_d;

  // Combinational datapath
  logic [WIDTH-1:0] bn;
  pg_t  [WIDTH-1:0] s1_pg;
  pg_t  [WIDTH-1:0] lvl_in  [1:LEVELS];
  pg_t  [WIDTH-1:0] lvl_out [1:LEVELS];
  logic [WIDTH-1:0] diff_c;
  logic             c_out, bout_c, ovf_c;
  logic             unused_grp_p;

  // ---------------------------------------------------------------------
  // Flow control: a stage may load when it is empty or its content moves
  // on this cycle. The chain runs combinationally from out_ready, which
  // lets bubbles collapse while the output is stalled.
  // ---------------------------------------------------------------------
  always_comb begin
    en3  = ~v3_q | out_ready;
    en2  = ~v2_q | en3;
    en1  = ~v1_q | en2;
    ld1  = en1 & in_valid;
    ld2  = en2 & v1_q;
    ld3  = en3 & v2_q;
    v1_d = en1 ? in_valid : v1_q;
    v2_d = en2 ? v1_q     : v2_q;
    v3_d = en3 ? v2_q     : v3_q;
  end

  assign in_ready = en1;

  // ---------------------------------------------------------------------
  // Stage 1 capture: complement b, form bitwise p/g and the carry-in pair.
  // ---------------------------------------------------------------------
  assign bn = ~b;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through
    // this block leaves it unassigned, which would infer a latch.
    s1_p_d     = s1_p_q;
    s1_g_d     = s1_g_q;
    s1_cin_d   = s1_cin_q;
    s1_a_msb_d = s1_a_msb_q;
    s1_b_msb_d = s1_b_msb_q;
    if (ld1) begin
      s1_p_d       = a ^ bn;
      s1_g_d       = a & bn;
      s1_cin_d.p   = 1'b0;
      s1_cin_d.g   = ~bin;
      s1_a_msb_d   = a[WIDTH-1];
      s1_b_msb_d   = b[WIDTH-1];
    end
  end

  // Assemble the prefix vector: carry-in at position 0, bit i at i+1.
  // Bit WIDTH-1 never enters the tree; its carry-out is formed explicitly.
  always_comb begin
    s1_pg[0] = s1_cin_q;
    for (int i = 1; i < WIDTH; i++) begin
      s1_pg[i].p = s1_p_q[i-1];
      s1_pg[i].g = s1_g_q[i-1];
    end
  end

  // ---------------------------------------------------------------------
  // Prefix tree: levels 1..SPLIT_LEVEL read stage 1, the remaining levels
  // read the stage 2 register.
  // ---------------------------------------------------------------------
  for (genvar k = 1; k <= LEVELS; k++) begin : g_level
    if (k == SPLIT_LEVEL + 1) begin : g_from_s2
      assign lvl_in[k] = s2_pg_q;
    end else if (k == 1) begin : g_from_s1
      assign lvl_in[k] = s1_pg;
    end else begin : g_chain
      assign lvl_in[k] = lvl_out[k-1];
    end

    ppa_sub_prefix_level #(
      .DIST  (1 << (k - 1)),
      .WIDTH (WIDTH)
    ) u_level (
      .pg_i (lvl_in[k]),
      .pg_o (lvl_out[k])
    );
  end

  always_comb begin
    s2_pg_d    = s2_pg_q;
    s2_p_d     = s2_p_q;
    s2_g_msb_d = s2_g_msb_q;
    s2_a_msb_d = s2_a_msb_q;
    s2_b_msb_d = s2_b_msb_q;
    if (ld2) begin
      s2_pg_d    = lvl_out[SPLIT_LEVEL];
      s2_p_d     = s1_p_q;
      s2_g_msb_d = s1_g_q[WIDTH-1];
      s2_a_msb_d = s1_a_msb_q;
      s2_b_msb_d = s1_b_msb_q;
    end
  end

  // ---------------------------------------------------------------------
  // Post-processing: sum bits, carry-out of the MSB, borrow and overflow.
  // ---------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      diff_c[i] = s2_p_q[i] ^ lvl_out[LEVELS][i].g;
    end
    c_out  = s2_g_msb_q | (s2_p_q[WIDTH-1] & lvl_out[LEVELS][WIDTH-1].g);
    bout_c = ~c_out;
    ovf_c  = (s2_a_msb_q ^ s2_b_msb_q) & (diff_c[WIDTH-1] ^ s2_a_msb_q);
  end

  // Final group propagate is not needed once the carries are known.
  always_comb begin
    unused_grp_p = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      unused_grp_p = unused_grp_p ^ lvl_out[LEVELS][i].p;
    end
  end

  // Output registers only load real beats so they stay at their reset
  // value until the first result arrives.
  always_comb begin
    diff_d = diff_q;
    bout_d = bout_q;
    ovf_d  = ovf_q;
    if (ld3) begin
      diff_d = diff_c;
      bout_d = bout_c;
      ovf_d  = ovf_c;
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  // NOTE: stage 1/2 data flops carry no reset; their valid bits qualify
  // them, so stale data after reset is never observed.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    s1_p_q     <= s1_p_d;
    s1_g_q     <= s1_g_d;
    s1_cin_q   <= s1_cin_d;
    s1_a_msb_q <= s1_a_msb_d;
    s1_b_msb_q <= s1_b_msb_d;
    s2_pg_q    <= s2_pg_d;
    s2_p_q     <= s2_p_d;
    s2_g_msb_q <= s2_g_msb_d;
    s2_a_msb_q <= s2_a_msb_d;
    s2_b_msb_q <= s2_b_msb_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign out_valid = v3_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_ppa_sub_pipe.sv
// tb_ppa_sub_pipe: self-checking bench for ppa_sub_pipe.
// Three instances (WIDTH = 8, 16, 32) share one input stream and one
// out_ready. Each keeps a queue of expected results computed with plain
// integer arithmetic; the queue length is also the number of beats in the
// pipe, which fixes what in_ready must be every cycle.
module tb_ppa_sub_pipe;

  typedef struct {
    logic [31:0] diff;
    logic        bout;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, bin_in;
  logic [31:0] a_in, b_in;

  logic        in_ready8, out_valid8, bout8, ovf8;
  logic [7:0]  diff8;
  logic        in_ready16, out_valid16, bout16, ovf16;
  logic [15:0] diff16;
  logic        in_ready32, out_valid32, bout32, ovf32;
  logic [31:0] diff32;

  logic        in_ready_v  [3];
  logic        out_valid_v [3];
  logic        bout_v      [3];
  logic        ovf_v       [3];
  logic [31:0] diff_v      [3];

  exp_t sb_q [3][$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  ppa_sub_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .a(a_in[7:0]), .b(b_in[7:0]), .bin(bin_in), .out_valid(out_valid8),
    .out_ready(out_ready), .diff(diff8), .bout(bout8), .ovf(ovf8)
  );

  ppa_sub_pipe #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .a(a_in[15:0]), .b(b_in[15:0]), .bin(bin_in), .out_valid(out_valid16),
    .out_ready(out_ready), .diff(diff16), .bout(bout16), .ovf(ovf16)
  );

  ppa_sub_pipe #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .a(a_in), .b(b_in), .bin(bin_in), .out_valid(out_valid32),
    .out_ready(out_ready), .diff(diff32), .bout(bout32), .ovf(ovf32)
  );

  assign in_ready_v[0]  = in_ready8;
  assign in_ready_v[1]  = in_ready16;
  assign in_ready_v[2]  = in_ready32;
  assign out_valid_v[0] = out_valid8;
  assign out_valid_v[1] = out_valid16;
  assign out_valid_v[2] = out_valid32;
  assign bout_v[0]      = bout8;
  assign bout_v[1]      = bout16;
  assign bout_v[2]      = bout32;
  assign ovf_v[0]       = ovf8;
  assign ovf_v[1]       = ovf16;
  assign ovf_v[2]       = ovf32;
  assign diff_v[0]      = {24'd0, diff8};
  assign diff_v[1]      = {16'd0, diff16};
  assign diff_v[2]      = diff32;

  function automatic int width_of(input int idx);
    return 8 << idx;
  endfunction

  // Reference: integer subtraction at the given width.
  function automatic exp_t model(input int w, input logic [31:0] a,
                                 input logic [31:0] b, input logic bi);
    exp_t   m;
    longint full, half, ua, ub, sa, sb, r;
    full   = longint'(1) << w;
    half   = full >> 1;
    ua     = longint'({32'd0, a}) & (full - 1);
    ub     = longint'({32'd0, b}) & (full - 1);
    r      = ua - ub - longint'({63'd0, bi});
    m.diff = 32'(r & (full - 1));
    m.bout = (ua < ub + longint'({63'd0, bi}));
    sa     = (ua >= half) ? ua - full : ua;
    sb     = (ub >= half) ? ub - full : ub;
    r      = sa - sb - longint'({63'd0, bi});
    m.ovf  = (r < -half) || (r >= half);
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample handshake at the falling edge, score every
  // instance, then step to just after the next rising edge.
  task automatic cycle(output logic acc16);
    exp_t  e;
    string w;
    @(negedge clk);
    acc16 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w = $sformatf("w%0d", width_of(i));
      check({"in_ready_", w}, 32'(in_ready_v[i]),
            32'(out_ready || (sb_q[i].size() < 3)));
      if (out_valid_v[i] && out_ready) begin
        check({"result_expected_", w}, 32'(sb_q[i].size() != 0), 32'd1);
        if (sb_q[i].size() != 0) begin
          e = sb_q[i].pop_front();
          check({"diff_", w}, diff_v[i], e.diff);
          check({"bout_", w}, 32'(bout_v[i]), 32'(e.bout));
          check({"ovf_", w},  32'(ovf_v[i]),  32'(e.ovf));
        end
      end
      if (in_valid && in_ready_v[i]) begin
        sb_q[i].push_back(model(width_of(i), a_in, b_in, bin_in));
        if (i == 1) acc16 = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    logic dummy;
    cycle(dummy);
  endtask

  // Single beat through an otherwise idle pipe, checked on the 16-bit unit.
  task automatic send_one(input string tag, input logic [31:0] a,
                          input logic [31:0] b, input logic bi,
                          input logic [15:0] ed, input logic eb,
                          input logic eo);
    logic acc;
    int   waited;
    a_in = a; b_in = b; bin_in = bi; in_valid = 1'b1; out_ready = 1'b1;
    cycle(acc);
    check({tag, "_accept"}, 32'(acc), 32'd1);
    in_valid = 1'b0; a_in = $urandom; b_in = $urandom;
    waited = 0;
    while (!out_valid16 && waited < 8) begin
      tick();
      waited++;
    end
    check({tag, "_valid"}, 32'(out_valid16), 32'd1);
    check({tag, "_diff"},  32'(diff16), 32'(ed));
    check({tag, "_bout"},  32'(bout16), 32'(eb));
    check({tag, "_ovf"},   32'(ovf16),  32'(eo));
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    logic        saw_low, prev_stall;
    logic [15:0] prev_diff;
    int          n, consumed, cyc;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a_in = '0; b_in = '0; bin_in = 1'b0;
    #12;
    check("rst_out_valid", 32'(out_valid16), 32'd0);
    check("rst_diff",      32'(diff16),      32'd0);
    check("rst_bout",      32'(bout16),      32'd0);
    check("rst_ovf",       32'(ovf16),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_reset", 32'(in_ready16), 32'd1);

    // Latency: accepted in cycle 0, result visible in cycle 3.
    a_in = 32'h0005; b_in = 32'h0003; bin_in = 1'b0; in_valid = 1'b1;
    cycle(acc);
    check("lat_accept", 32'(acc), 32'd1);
    in_valid = 1'b0;
    check("lat_c1_valid", 32'(out_valid16), 32'd0);
    tick();
    check("lat_c2_valid", 32'(out_valid16), 32'd0);
    tick();
    check("lat_c3_valid", 32'(out_valid16), 32'd1);
    check("lat_diff",     32'(diff16), 32'h0002);
    check("lat_bout",     32'(bout16), 32'd0);
    check("lat_ovf",      32'(ovf16),  32'd0);
    tick();

    // Borrow and overflow corners.
    send_one("zero_minus_one", 32'h0000, 32'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    send_one("zero_minus_bin", 32'h0000, 32'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    send_one("min_minus_one",  32'h8000, 32'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    send_one("max_minus_neg1", 32'h7FFF, 32'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);

    // Backpressure burst: 5 beats, output stalled in cycles 4..7.
    saw_low = 1'b0; prev_stall = 1'b0; prev_diff = '0; n = 0; consumed = 0;
    for (int c = 0; c < 24; c++) begin
      in_valid  = (n < 5);
      a_in      = 32'h10 + 32'(n);
      b_in      = 32'(n);
      bin_in    = 1'b0;
      out_ready = !(c >= 4 && c <= 7);
      #1;
      if (!in_ready16) saw_low = 1'b1;
      if (out_valid16 && !out_ready) begin
        if (prev_stall) check("burst_stall_hold", 32'(diff16), 32'(prev_diff));
        prev_stall = 1'b1;
        prev_diff  = diff16;
      end else begin
        prev_stall = 1'b0;
      end
      if (out_valid16 && out_ready) begin
        check("burst_diff", 32'(diff16), 32'h10);
        consumed++;
      end
      cycle(acc);
      if (acc) n++;
    end
    in_valid = 1'b0;
    check("burst_in_ready_dropped", 32'(saw_low), 32'd1);
    check("burst_accepted", 32'(n), 32'd5);
    check("burst_consumed", 32'(consumed), 32'd5);

    // Reset with two beats in flight.
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; a_in = $urandom; b_in = $urandom; bin_in = 1'b0;
      cycle(acc);
    end
    in_valid = 1'b0;
    tick();
    tick();
    check("inflight_valid", 32'(out_valid16), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid16", 32'(out_valid16), 32'd0);
    check("async_rst_valid8",  32'(out_valid8),  32'd0);
    check("async_rst_valid32", 32'(out_valid32), 32'd0);
    check("async_rst_diff",    32'(diff16),      32'd0);
    check("async_rst_bout",    32'(bout16),      32'd0);
    for (int i = 0; i < 3; i++) sb_q[i].delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(in_ready16), 32'd1);
    check("post_rst_valid",    32'(out_valid16), 32'd0);
    out_ready = 1'b1;
    repeat (6) tick();
    check("no_stale_result", 32'(out_valid16), 32'd0);

    // Random soak with random handshakes on both sides.
    n = 0; cyc = 0;
    while (n < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      case ($urandom_range(7))
        0:       a_in = 32'h0;
        1:       a_in = 32'hFFFF_FFFF;
        default: a_in = $urandom;
      endcase
      case ($urandom_range(7))
        0:       b_in = 32'h0;
        1:       b_in = 32'hFFFF_FFFF;
        default: b_in = $urandom;
      endcase
      bin_in = 1'($urandom_range(1));
      cycle(acc);
      if (acc) n++;
      cyc++;
    end
    check("soak_beats", 32'(n), 32'd10000);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("drain_empty_w%0d", width_of(i)), 32'(sb_q[i].size()), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ppa_sub_pipe.md
Name: ppa_sub_pipe

Overview:
- Pipelined parallel-prefix subtractor. Computes diff = a - b - bin and the borrow-out.
- The "other direction" of the team's Kogge-Stone adder: the same radix-2 prefix structure with complemented operand and carry inversion.
- Three register stages, each with valid/ready flow control, so it can sit directly in a datapath between a producer and a consumer that can stall.

Parameters:
- WIDTH, 16, operand width. Legal values: 8, 16, 32 (a power of two).
- LEVELS, $clog2(WIDTH), number of prefix levels. Derived only; never overridden.

Ports:
- clk  input  1  sole clock; all flops are rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  (a - b - bin) mod 2^WIDTH.
- bout  output  1  borrow-out: 1 iff a < b + bin, unsigned.
- ovf  output  1  signed overflow of the two's-complement subtraction.

Behaviour:
- Pre-processing, per bit i:
  - bn[i] = ~b[i]
  - p[i] = a[i] ^ bn[i]
  - g[i] = a[i] & bn[i]
  - Carry-in position: g_lsb = ~bin, p_lsb = 0.
- Prefix cells:
  - Black cell: g_out = g_hi | (p_hi & g_lo); p_out = p_hi & p_lo.
  - Level k spans distance 2^(k-1). Positions below that distance pass through unchanged.
- Post-processing:
  - diff[i] = p[i] ^ G[i-1], where G[-1] = ~bin.
  - c_out = g[W-1] | (p[W-1] & G[W-2]).
  - bout = ~c_out.
  - ovf = (a[W-1] ^ b[W-1]) & (diff[W-1] ^ a[W-1]).
- Pipeline registers:
  - S1 captures p, g, the carry-in pair, and the raw a/b MSBs.
  - S2 captures the group p/g after prefix level ceil(LEVELS/2).
  - S3 captures diff, bout and ovf after the remaining levels and post-processing.
  - Outputs are driven directly from S3 flops; there is no combinational path from a/b to the outputs.
- Latency: exactly 3 cycles from an accepted input beat to out_valid when there is no backpressure.
- Throughput: one beat per cycle while out_ready = 1.
- Handshake:
  - A beat is accepted when in_valid & in_ready.
  - A result is consumed when out_valid & out_ready.
  - While out_valid = 1 and out_ready = 0, diff, bout and ovf hold stable.
  - The producer may drive any value on a, b, bin while in_valid = 0.
- Per-stage valid bits v1..v3. Stage k loads when ~v_k | adv_k.
  - adv3 = out_ready.
  - adv_k = ~v_{k+1} | adv_{k+1}.
  - Bubbles collapse: with the output stalled, up to 3 beats are held.
  - in_ready = ~v1 | adv1. This is combinational from out_ready through the valid bits; it does not depend on a, b or in_valid.
- Full: v1 = v2 = v3 = 1 and out_ready = 0 gives in_ready = 0. No beat is lost and no beat is duplicated.
- Simultaneous accept and consume in a full pipe: all stages shift, and in_ready = 1 that cycle.
- Reset, asserted asynchronously (including mid-operation):
  - v1..v3 = 0, out_valid = 0, diff = 0, bout = 0, ovf = 0.
  - in_ready = 1 in the first cycle after release.
  - In-flight beats are discarded.
- Data flops in S1/S2 need not be reset; valid bits and all output flops must be.

Decomposition:
- Package ppa_sub_pkg holds:
  - localparam function levels(width);
  - typedef struct pg_t { logic p; logic g; };
  - the stage-split constant SPLIT_LEVEL = (LEVELS+1)/2.
- One sub-module: ppa_sub_prefix_level, with parameters DIST and WIDTH. It is one combinational Kogge-Stone level of black cells plus pass-throughs and is instantiated LEVELS times via generate.
- Pipeline registers and the handshake stay in the top module.

Test Plan:
- a=0x0005, b=0x0003, bin=0, one beat, out_ready=1 -> out_valid high 3 cycles after accept; diff=0x0002, bout=0, ovf=0.
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0. Then a=0x0000, b=0x0000, bin=1 -> diff=0xFFFF, bout=1.
- a=0x8000, b=0x0001 -> diff=0x7FFF, bout=0, ovf=1. Then a=0x7FFF, b=0xFFFF -> diff=0x8000, bout=1, ovf=1.
- Backpressure burst:
  - Stimulus: 5 back-to-back beats (a = 0x0010 + n, b = n, n = 0..4); out_ready low for cycles 4–7, then high.
  - Required: in_ready drops once 3 beats are held; results are 0x0010 ×5, in order, with no loss or duplication; outputs are stable while stalled.
- Reset mid-flight: 2 beats in the pipe, pulse rst_n low asynchronously between clock edges -> out_valid=0 and diff=0 immediately; in_ready=1 after release; no stale result ever appears.
- Random soak: 10k random a/b/bin with random in_valid/out_ready -> every result matches the reference model (a - b - bin, borrow, signed overflow), in order, with no loss or duplication, for WIDTH = 8, 16 and 32.
